reg_hex_dumper: RTL and testbench

- Parametrised engine that walks a range of register-file entries and renders each one as a line of hex ASCII into the character framebuffer.
- Replaces the inline GET_REG/DISP_BYTE debug sub-FSM in the processor top; the core only pulses start and waits for done.
- Adds the following over the inline sub-FSM: configurable word width and register count, a selectable register range and screen row, an optional "xNN: " label, write back-pressure, and abort.

---
 rtl/reg_hex_dumper.sv | 142 ++++++++++++++
 tb/tb_reg_hex_dumper.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_hex_dumper.sv
// reg_hex_dumper: walks a register range and renders each entry as one line of hex ASCII into the framebuffer
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   start, abort    begin a dump (sampled in IDLE) / terminate a dump in progress
//   first_reg       first register index to dump
//   last_reg        last register index to dump (inclusive, clamped to NUM_REGS-1)
//   base_row        screen row used for first_reg
//   busy, done      dump in progress / one-cycle completion pulse
//   reg_addr        register-file debug read index
//   reg_data        register-file debug read data (combinational from reg_addr)
//   wr_en           framebuffer write request
//   wr_addr         framebuffer character address
//   wr_data         {ascii, ATTR}
//   wr_ready        framebuffer accepts the write when wr_en && wr_ready
module reg_hex_dumper #(
  parameter int          WORD_SIZE   = 32,
  parameter int          NUM_REGS    = 32,
  parameter int          REG_ADDR_W  = 5,
  parameter int          SCREEN_COLS = 80,
  parameter int          ADDR_W      = 13,
  parameter logic [23:0] ATTR        = 24'hFFFFFF,
  parameter bit          LABEL_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [REG_ADDR_W-1:0] first_reg,
  input  logic [REG_ADDR_W-1:0] last_reg,
  input  logic [ADDR_W-1:0]     base_row,
  output logic                  busy,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] reg_addr,
  input  logic [WORD_SIZE-1:0]  reg_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [31:0]           wr_data,
  input  logic                  wr_ready
);
  localparam int C_HEX = WORD_SIZE / 4;
  localparam int C_LBL = LABEL_EN ? 5 : 0;
  localparam int C_CH  = C_LBL + C_HEX;
  localparam int IW    = $clog2(C_CH + 1);
  localparam logic [REG_ADDR_W-1:0] MAX_REG = REG_ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, EMIT, NEXT_REG, DONE} state_t;

  state_t                state;
  logic [REG_ADDR_W-1:0] first_q, last_q, cur, last_c;
  logic [ADDR_W-1:0]     base_q, row_addr;
  logic [WORD_SIZE-1:0]  sh, sh_nx;
  logic [IW-1:0]         idx;

  function automatic logic [7:0] hex_ch(input logic [3:0] d);
    return d < 4'd10 ? 8'h30 + 8'(d) : 8'h37 + 8'(d);
  endfunction

  // Character i of the line for register r; nib is the hex digit due if i is past the label.
  function automatic logic [7:0] char_at(input logic [3:0] nib, input logic [IW-1:0] i,
                                         input logic [REG_ADDR_W-1:0] r);
    int unsigned n;
    n = 32'(r);
    return int'(i) >= C_LBL ? hex_ch(nib)
         : i == IW'(0) ? 8'h78
         : i == IW'(1) ? 8'(48 + n / 10)
         : i == IW'(2) ? 8'(48 + n % 10)
         : i == IW'(3) ? 8'h3A : 8'h20;
  endfunction

  assign last_c   = last_reg > MAX_REG ? MAX_REG : last_reg;
  // Label characters leave the word untouched; each accepted hex digit shifts the next one to the top.
  assign sh_nx    = int'(idx) >= C_LBL ? sh << 4 : sh;
  assign row_addr = ADDR_W'((32'(base_q) + 32'(cur) - 32'(first_q)) * SCREEN_COLS);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      reg_addr <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      first_q  <= '0;
      last_q   <= '0;
      base_q   <= '0;
      cur      <= '0;
      sh       <= '0;
      idx      <= '0;
    end else if (abort && state != DONE) begin
      // Also covers IDLE, so abort beats a simultaneous start.
      state <= IDLE;
      busy  <= 1'b0;
      wr_en <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          first_q  <= first_reg;
          last_q   <= last_c;
          base_q   <= base_row;
          cur      <= first_reg;
          reg_addr <= first_reg;
          state    <= first_reg > last_c ? DONE : FETCH;
          done     <= first_reg > last_c;
          busy     <= first_reg <= last_c;
        end
        FETCH: state <= LATCH;
        LATCH: begin
          sh      <= reg_data;
          idx     <= '0;
          wr_addr <= row_addr;
          wr_data <= {char_at(reg_data[WORD_SIZE-1 -: 4], '0, cur), ATTR};
          wr_en   <= 1'b1;
          state   <= EMIT;
        end
        EMIT: if (wr_ready) begin
          if (int'(idx) == C_CH - 1) begin
            wr_en <= 1'b0;
            state <= NEXT_REG;
          end else begin
            idx     <= idx + IW'(1);
            sh      <= sh_nx;
            wr_addr <= wr_addr + ADDR_W'(1);
            wr_data <= {char_at(sh_nx[WORD_SIZE-1 -: 4], idx + IW'(1), cur), ATTR};
          end
        end
        NEXT_REG: if (cur == last_q) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          cur      <= cur + REG_ADDR_W'(1);
          reg_addr <= cur + REG_ADDR_W'(1);
          state    <= FETCH;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_reg_hex_dumper.sv
// tb_reg_hex_dumper: table-driven and randomized checks of reg_hex_dumper against a line-rendering model
module tb_reg_hex_dumper;
  localparam logic [23:0] ATTR = 24'hFFFFFF;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  typedef struct { int f; int l; int b; int mode; int n; int lat; } vec_t;

  logic        clk = 0, rst = 0;
  logic        start = 0, abort = 0, wr_ready = 1;
  logic [4:0]  first_reg = 0, last_reg = 0;
  logic [12:0] base_row = 0;
  logic        busy, done, wr_en;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data, wr_data;
  logic [12:0] wr_addr;

  logic        start1 = 0, abort1 = 0, ready1 = 1;
  logic [4:0]  first1 = 0, last1 = 0;
  logic [12:0] base1 = 0;
  logic        busy1, done1, wr_en1;
  logic [4:0]  reg_addr1;
  logic [15:0] reg_data1;
  logic [31:0] wr_data1;
  logic [12:0] wr_addr1;

  logic [31:0] regs [32];
  logic [15:0] regs16 [32];

  assign reg_data  = regs[reg_addr];
  assign reg_data1 = regs16[reg_addr1];

  reg_hex_dumper u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .first_reg(first_reg), .last_reg(last_reg),
    .base_row(base_row), .busy(busy), .done(done), .reg_addr(reg_addr), .reg_data(reg_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready));

  reg_hex_dumper #(.WORD_SIZE(16), .LABEL_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .first_reg(first1), .last_reg(last1),
    .base_row(base1), .busy(busy1), .done(done1), .reg_addr(reg_addr1), .reg_data(reg_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_ready(ready1));

  int errors = 0, checks = 0, cyc = 0, mode = 0;
  int done_cnt = 0, done_cyc = 0, done1_cnt = 0, done1_cyc = 0;
  bit busy_seen = 0, prev_stall = 0;
  logic [12:0] prev_addr;
  logic [31:0] prev_data;
  wr_t got_q[$], got1_q[$], exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en && wr_ready) got_q.push_back('{int'(wr_addr), wr_data});
    if (wr_en1) got1_q.push_back('{int'(wr_addr1), wr_data1});
    if (busy) busy_seen = 1;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (done1) begin done1_cnt++; done1_cyc = cyc; end
    if (prev_stall && wr_en) begin
      checks++;
      if (wr_addr != prev_addr || wr_data != prev_data) begin
        errors++;
        $display("FAIL stall_hold: addr/data %0d/%h, held values %0d/%h", wr_addr, wr_data, prev_addr, prev_data);
      end
    end
    prev_stall = wr_en && !wr_ready;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endfunction

  // Expected framebuffer writes: each register becomes a text line at row b + (r - f).
  function automatic void build_exp(input int f, input int l, input int b, input bit wide);
    byte line[$];
    exp_q.delete();
    for (int r = f; r <= l && r < 32; r++) begin
      logic [31:0] v = wide ? regs[r] : 32'(regs16[r]);
      int nd = wide ? 8 : 4;
      line.delete();
      if (wide) begin
        line.push_back("x");
        line.push_back(byte'(48 + r / 10));
        line.push_back(byte'(48 + r % 10));
        line.push_back(":");
        line.push_back(" ");
      end
      for (int k = nd - 1; k >= 0; k--) begin
        int d = int'((v >> (4 * k)) & 32'hF);
        line.push_back(byte'(d < 10 ? 48 + d : 55 + d));
      end
      for (int i = 0; i < line.size(); i++)
        exp_q.push_back('{((b + r - f) * 80 + i) % 8192, {line[i], ATTR}});
    end
  endfunction

  function automatic void cmp_q(input string name, input bit sec);
    wr_t g[$];
    int bad = -1;
    if (sec) g = got1_q; else g = got_q;
    checks++;
    for (int i = 0; i < exp_q.size() && i < g.size(); i++)
      if (bad < 0 && (g[i].addr != exp_q[i].addr || g[i].data != exp_q[i].data)) bad = i;
    if (bad >= 0 || g.size() != exp_q.size()) begin
      errors++;
      if (bad >= 0)
        $display("FAIL %s: write %0d got addr %0d data %h, expected addr %0d data %h",
                 name, bad, g[bad].addr, g[bad].data, exp_q[bad].addr, exp_q[bad].data);
      else
        $display("FAIL %s: got %0d writes, expected %0d", name, g.size(), exp_q.size());
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (mode == 1) wr_ready = 1'($urandom_range(0, 1));
    else if (mode == 2) wr_ready = ~wr_ready;
    else wr_ready = 1;
  endtask

  task automatic run(input int f, input int l, input int b, input int m, output int lat);
    got_q.delete();
    done_cnt  = 0;
    busy_seen = 0;
    mode      = m;
    first_reg = 5'(f);
    last_reg  = 5'(l);
    base_row  = 13'(b);
    start     = 1;
    lat       = cyc;
    tick();
    start     = 0;
    first_reg = 5'($urandom);
    last_reg  = 5'($urandom);
    base_row  = 13'($urandom);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
    lat = done_cyc - lat;
    repeat (3) tick();
    mode = 0;
    build_exp(f, l, b, 1);
  endtask

  initial begin
    vec_t tv[7];
    int lat, n0, c0;
    tv[0] = '{5, 5, 2, 0, 13, 17};
    tv[1] = '{0, 31, 0, 0, 416, 513};
    tv[2] = '{7, 4, 0, 0, 0, 1};
    tv[3] = '{3, 3, 10, 2, 13, -1};
    tv[4] = '{30, 31, 5, 0, 26, 33};
    tv[5] = '{0, 0, 103, 0, 13, 17};
    tv[6] = '{12, 15, 50, 1, 52, -1};
    for (int i = 0; i < 32; i++) begin
      regs[i]   = 32'(i) * 32'h11111111;
      regs16[i] = 16'($urandom);
    end
    regs[5]   = 32'hDEADBEEF;
    regs16[2] = 16'h00AB;

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    repeat (3) tick();
    rst = 1;
    tick();

    foreach (tv[i]) begin
      run(tv[i].f, tv[i].l, tv[i].b, tv[i].mode, lat);
      chk($sformatf("v%0d_count", i), got_q.size(), tv[i].n);
      chk($sformatf("v%0d_done_pulses", i), done_cnt, 1);
      if (tv[i].lat >= 0) chk($sformatf("v%0d_latency", i), lat, tv[i].lat);
      if (tv[i].n == 0) chk($sformatf("v%0d_busy_seen", i), busy_seen, 0);
      cmp_q($sformatf("v%0d_content", i), 0);
      if (i == 0) begin
        chk("single_first_addr", got_q[0].addr, 160);
        chk("single_first_data", got_q[0].data, 32'h78FFFFFF);
        chk("single_last_addr", got_q[12].addr, 172);
        chk("single_last_data", got_q[12].data, 32'h46FFFFFF);
      end
      if (i == 1) begin
        chk("row31_addr", got_q[403].addr, 2480);
        chk("row31_x", got_q[403].data, 32'h78FFFFFF);
        chk("row31_hex0", got_q[408].data, 32'h31FFFFFF);
        chk("row31_hex7", got_q[415].data, 32'h46FFFFFF);
      end
    end

    for (int it = 0; it < 8; it++) begin
      int f, l, b, m;
      foreach (regs[j]) regs[j] = $urandom;
      f = $urandom_range(0, 31);
      l = f + $urandom_range(0, 3);
      if (l > 31) l = 31;
      b = $urandom_range(0, 150);
      m = $urandom_range(0, 1);
      run(f, l, b, m, lat);
      chk($sformatf("rand%0d_done_pulses", it), done_cnt, 1);
      if (m == 0) chk($sformatf("rand%0d_latency", it), lat, (l - f + 1) * 16 + 1);
      cmp_q($sformatf("rand%0d_content", it), 0);
    end

    got_q.delete();
    done_cnt  = 0;
    first_reg = 8;
    last_reg  = 12;
    base_row  = 20;
    start     = 1;
    tick();
    start = 0;
    n0 = 0;
    while (n0 < 400 && !(wr_en && wr_addr == 13'd1765)) begin tick(); n0++; end
    chk("abort_reached", n0 < 400, 1);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    repeat (30) tick();
    chk("abort_no_done", done_cnt, 0);
    build_exp(8, 12, 20, 1);
    while (exp_q.size() > 32) void'(exp_q.pop_back());
    cmp_q("abort_writes", 0);
    run(8, 12, 20, 0, lat);
    chk("restart_done_pulses", done_cnt, 1);
    chk("restart_latency", lat, 81);
    cmp_q("restart_content", 0);

    got_q.delete();
    done_cnt  = 0;
    busy_seen = 0;
    first_reg = 1;
    last_reg  = 2;
    start     = 1;
    abort     = 1;
    tick();
    start = 0;
    abort = 0;
    repeat (20) tick();
    chk("start_abort_busy", busy_seen, 0);
    chk("start_abort_writes", got_q.size(), 0);
    chk("start_abort_done", done_cnt, 0);

    got_q.delete();
    done_cnt  = 0;
    first_reg = 0;
    last_reg  = 3;
    base_row  = 0;
    start     = 1;
    tick();
    start = 0;
    repeat (6) tick();
    chk("areset_in_emit", wr_en, 1);
    #2 rst = 0;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_wr_en", wr_en, 0);
    chk("areset_outs", {done, reg_addr, wr_addr, wr_data}, 0);
    n0 = got_q.size();
    repeat (3) tick();
    rst = 1;
    repeat (10) tick();
    chk("areset_no_writes", got_q.size(), n0);
    chk("areset_no_done", done_cnt, 0);
    chk("areset_idle", busy, 0);

    for (int r = 0; r < 2; r++) begin
      int f = r == 0 ? 2 : 0;
      int l = r == 0 ? 2 : 5;
      int b = r == 0 ? 4 : 7;
      got1_q.delete();
      done1_cnt = 0;
      first1 = 5'(f);
      last1  = 5'(l);
      base1  = 13'(b);
      start1 = 1;
      c0 = cyc;
      tick();
      start1 = 0;
      for (int i = 0; i < 500 && done1_cnt == 0; i++) tick();
      repeat (3) tick();
      chk($sformatf("w16_%0d_done_pulses", r), done1_cnt, 1);
      chk($sformatf("w16_%0d_latency", r), done1_cyc - c0, (l - f + 1) * 7 + 1);
      build_exp(f, l, b, 0);
      cmp_q($sformatf("w16_%0d_content", r), 1);
      if (r == 0) begin
        chk("w16_count", got1_q.size(), 4);
        chk("w16_first_addr", got1_q[0].addr, 320);
        chk("w16_char_a", got1_q[2].data, 32'h41FFFFFF);
        chk("w16_char_b", got1_q[3].data, 32'h42FFFFFF);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
